periodic_event_scheduler: RTL
=============================

Name: periodic_event_scheduler

Overview:
- Generates periodic events on NUM_CH independent channels. Each channel has a programmable period.
- All channels share one registered event output with a valid/ready handshake. Round-robin arbitration decides which channel is granted when more than one has an event pending.
- Acts as the sequencer that replaces free-running delay-driven periodic processes with cycle-accurate scheduled strobes for downstream test/datapath logic.

Parameters:
- NUM_CH, 4, number of channels (2..8); channel index width CW = clog2(NUM_CH).
- PW, 8, period/counter width in bits.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk.
- cfg_we  input  1  configuration write strobe.
- cfg_ch  input  CW  channel selected by the write.
- cfg_period  input  PW  period in cycles; 0 disables the channel.
- evt_valid  output  1  event available.
- evt_ch  output  CW  channel of the presented event.
- evt_ready  input  1  consumer accepts the event.
- pending  output  NUM_CH  per-channel pending flags (visible state).
- overrun  output  NUM_CH  sticky per-channel overrun flags.

Behaviour:
- Reset (rst_n=0 at an edge): all periods=0, all counters=0, pending=0, overrun=0, evt_valid=0, evt_ch=0. Round-robin pointer "last" = NUM_CH-1, so channel 0 has first priority.
- Config write at edge t:
  - period[cfg_ch] <= cfg_period; counter[cfg_ch] <= cfg_period-1 (or 0 if cfg_period=0).
  - pending[cfg_ch] <= 0 and overrun[cfg_ch] <= 0. The write wins over a tick on that channel at the same edge.
  - Other channels are unaffected.
  - If the written channel is currently held in the output register, that event still completes normally.
- Tick rule, per enabled channel (period P ≥ 1):
  - If counter==0 at an edge: counter <= P-1 and a tick occurs. Otherwise counter decrements.
  - First tick lands at edge t+P after the write at t. Later ticks follow every P edges.
  - P=1 ticks every edge.
- Pending/overrun on a tick:
  - Tick with pending=0: pending <= 1.
  - Tick with pending=1 and the channel not granted this edge: pending stays 1 and overrun <= 1 (sticky).
  - Tick on the same edge the channel is granted: pending stays 1 as a new event, with no overrun.
- Output register is "free" when evt_valid==0 or (evt_valid && evt_ready).
- Grant (only when the output register is free and any pending bit is 1):
  - Winner = first pending channel searching from last+1 upward, wrapping modulo NUM_CH.
  - evt_valid <= 1, evt_ch <= winner, pending[winner] cleared, last <= winner.
- If the register is free and nothing is pending: evt_valid <= 0.
- While evt_valid && !evt_ready: evt_ch is held stable and no grant occurs.
- Latency: pending set at edge e → evt_valid=1 after edge e+1, provided the register is free.
- Back-to-back: with evt_ready held high, one event is presented per cycle.
- Disabled channel (P=0): never ticks. An existing pending flag is cleared by the config write itself.
- Reset mid-operation: all state is cleared at that edge, including any held event; no event is emitted.

Test Plan:
- Reset, then write ch0 P=5 at edge 0 with evt_ready=1 → pending[0] after edge 5, evt_valid/evt_ch=0 after edge 6; this repeats every 5 cycles; overrun=0.
- Write ch0..ch3 P=4 on the same cycle (sequential writes aligned so that all channels tick on one edge), evt_ready=1 → events on 4 consecutive cycles in order 0,1,2,3. Next round again 0,1,2,3 (pointer wraps).
- Ch1 P=2, evt_ready=0 for 10 cycles → evt_valid=1 with evt_ch=1 held stable; pending[1]=1, overrun[1]=1. Raising evt_ready drains the held event and then the pending one; overrun stays 1 until ch1 is rewritten.
- Ch2 P=1, evt_ready=1 → evt_valid continuously high, evt_ch=2 every cycle, overrun[2] stays 0 (tick-at-grant rule).
- Write ch0 P=0 while pending[0]=1 → pending[0] clears at that edge and no further ch0 events occur.
- Drive rst_n=0 for one edge while evt_valid=1 → evt_valid=0, pending=0, overrun=0 after that edge; no events occur until channels are reconfigured.

Source files
------------

// File: rtl/periodic_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : periodic_event_scheduler
// Description : NUM_CH independent programmable-period tick generators that
//               share one registered valid/ready event output. Round-robin
//               arbitration picks among pending channels; per-channel
//               pending and sticky overrun flags are exported.
// Revision    : 1.0 - initial release
// ============================================================================
module periodic_event_scheduler #(
    parameter  int NUM_CH = 4,
    parameter  int PW     = 8,
    localparam int CW     = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [PW-1:0]     cfg_period,
    output logic              evt_valid,
    output logic [CW-1:0]     evt_ch,
    input  logic              evt_ready,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overrun
);

    localparam logic [PW-1:0] c_ONE     = PW'(1);
    localparam logic [PW-1:0] c_ZERO    = {PW{1'b0}};
    localparam logic [CW-1:0] c_LAST_RS = CW'(NUM_CH - 1);

    logic [PW-1:0]     r_period [NUM_CH];
    logic [PW-1:0]     r_count  [NUM_CH];
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] r_overrun;
    logic              r_evt_valid;
    logic [CW-1:0]     r_evt_ch;
    logic [CW-1:0]     r_last;

    logic [NUM_CH-1:0] w_tick;
    logic [NUM_CH-1:0] w_wr;
    logic [NUM_CH-1:0] w_grant_vec;
    logic              w_free;
    logic              w_found;
    logic              w_grant;
    logic [CW-1:0]     w_winner;

    assign w_free  = !r_evt_valid || evt_ready;
    assign w_grant = w_free && w_found;

    // Per-channel tick, config-write select and grant decode.
    always_comb begin
        w_tick      = '0;
        w_wr        = '0;
        w_grant_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_tick[i]      = (r_period[i] != c_ZERO) && (r_count[i] == c_ZERO);
            w_wr[i]        = cfg_we && (cfg_ch == CW'(i));
            w_grant_vec[i] = w_grant && (w_winner == CW'(i));
        end
    end

    // Round-robin search: first pending channel after the last winner.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!w_found && r_pending[(int'(r_last) + k) % NUM_CH]) begin
                w_found  = 1'b1;
                w_winner = CW'((int'(r_last) + k) % NUM_CH);
            end
        end
    end

    // Channel state: period, down-counter, pending and sticky overrun.
    // A config write overrides any tick on that channel in the same cycle;
    // a tick coinciding with a grant re-arms pending without overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_period[i] <= c_ZERO;
                r_count[i]  <= c_ZERO;
            end
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr[i]) begin
                    r_period[i]  <= cfg_period;
                    r_count[i]   <= (cfg_period == c_ZERO) ? c_ZERO : (cfg_period - c_ONE);
                    r_pending[i] <= 1'b0;
                    r_overrun[i] <= 1'b0;
                end else begin
                    if (r_period[i] != c_ZERO) begin
                        r_count[i] <= (r_count[i] == c_ZERO) ? (r_period[i] - c_ONE)
                                                             : (r_count[i] - c_ONE);
                    end
                    if (w_grant_vec[i]) begin
                        r_pending[i] <= w_tick[i];
                    end else if (w_tick[i]) begin
                        r_pending[i] <= 1'b1;
                        if (r_pending[i]) begin
                            r_overrun[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Output register: load a winner when free, hold while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_last      <= c_LAST_RS;
        end else if (w_free) begin
            if (w_found) begin
                r_evt_valid <= 1'b1;
                r_evt_ch    <= w_winner;
                r_last      <= w_winner;
            end else begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_ch    = r_evt_ch;
    assign pending   = r_pending;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
